circ_node_injector: RTL and testbench

Compute-node side of a circulant-NoC router: accepts destination requests from the node logic, queues them, and injects them one at a time into the router's `in_free` port as single-cycle packet pulses. Enforces a minimum idle gap between injections, because `in_free` has top priority in the router and back-to-back injections would starve transit traffic. Also monitors the router's delivery flag `out_data` and keeps transmit/receive statistics. One instance per node, sitting between the node's IP logic and its router.

---
 rtl/circ_noc_pkg.sv | 36 +++
 rtl/circ_req_fifo.sv | 81 ++++++++
 rtl/circ_node_injector.sv | 175 +++++++++++++++++
 tb/tb_circ_node_injector.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circ_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : circ_noc_pkg
// Description : Shared defaults, packet field layout, injection-word builder
//               and injector FSM encoding for the circulant-NoC node side.
// Revision    : 1.0 - initial release
// ============================================================================
package circ_noc_pkg;

  // Default node-number and router packet widths
  localparam int K_DEF  = 8;
  localparam int N2_DEF = 17;

  // Packet field positions
  localparam int VALID_BIT = N2_DEF - 1;
  localparam int DEST_MSB  = K_DEF - 1;
  localparam int DEST_LSB  = 0;

  // Injector FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } inj_state_e;

  // Valid bit set, reserved middle bits zero, destination in the low field
  function automatic logic [N2_DEF-1:0] make_inject_word(input logic [K_DEF-1:0] dest);
    logic [N2_DEF-1:0] word;
    word                    = '0;
    word[VALID_BIT]         = 1'b1;
    word[DEST_MSB:DEST_LSB] = dest;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/circ_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : circ_req_fifo
// Description : Synchronous request FIFO (power-of-two depth) with
//               combinational read port and async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module circ_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]    count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (count_q == c_depth);
  assign empty     = (count_q == '0);
  // Overflow/underflow requests are dropped here so callers cannot corrupt state
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; push+pop keeps count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + c_ptr_one;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // Storage array needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/circ_node_injector.sv
`default_nettype none
// ============================================================================
// Module      : circ_node_injector
// Description : Node-side injector for a circulant-NoC router. Queues
//               destination requests, injects one single-cycle packet pulse
//               at a time into in_free with a minimum idle gap, and keeps
//               saturating tx/rx statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module circ_node_injector
  import circ_noc_pkg::*;
#(
  parameter int NODE_COUNT = 225,
  parameter int K          = 8,
  parameter int N2         = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K-1:0]  router_name,
  input  logic          req_valid,
  input  logic [K-1:0]  req_dest,
  output logic          req_ready,
  output logic [N2-1:0] pkt_out,
  output logic          busy,
  output logic          err_bad_dest,
  input  logic          rx_data,
  output logic          rx_pulse,
  output logic [15:0]   tx_count,
  output logic [15:0]   rx_count
);

  // Gap counter holds GAP-1 at most; keep at least one bit so GAP=0/1 elaborate
  localparam int                 c_gap_w      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load   = c_gap_w'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [K:0]         c_node_limit = (K+1)'(NODE_COUNT);
  localparam logic [15:0]        c_cnt_max    = 16'hFFFF;

  inj_state_e          state_q, state_d;
  logic [N2-1:0]       pkt_out_q, pkt_out_d;
  logic [c_gap_w-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]         tx_count_q, tx_count_d;
  logic [15:0]         rx_count_q, rx_count_d;
  logic                rx_pulse_q, rx_pulse_d;
  logic                err_bad_dest_q, err_bad_dest_d;

  logic                w_accept;
  logic                w_dest_bad;
  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [K-1:0]        w_fifo_dout;
  logic [N2-1:0]       w_inject_word;
  logic                w_unused_name;

  // Own node number is informational only: a destination equal to it is a
  // legal local delivery handled by the router, so no logic depends on it.
  assign w_unused_name = ^router_name;

  // Ready depends only on occupancy so the handshake never loops through req_valid
  assign req_ready   = !w_fifo_full;
  assign w_accept    = req_valid && req_ready;
  assign w_dest_bad  = ({1'b0, req_dest} >= c_node_limit);
  // Out-of-range requests are consumed by the handshake but never stored
  assign w_fifo_push = w_accept && !w_dest_bad;

  circ_req_fifo #(
    .WIDTH (K),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_fifo_push),
    .push_data (req_dest),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_dout),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Use the shared word builder when widths match the package defaults
  if ((K == K_DEF) && (N2 == N2_DEF)) begin : g_word_pkg
    assign w_inject_word = make_inject_word(w_fifo_dout);
  end else begin : g_word_generic
    // Same layout as the package builder for non-default widths
    always_comb begin
      w_inject_word         = '0;
      w_inject_word[N2-1]   = 1'b1;
      w_inject_word[K-1:0]  = w_fifo_dout;
    end
  end

  // Injection FSM: pop in IDLE, one-cycle SEND pulse, then GAP idle cycles
  always_comb begin
    state_d    = state_q;
    pkt_out_d  = pkt_out_q;
    gap_cnt_d  = gap_cnt_q;
    tx_count_d = tx_count_q;
    w_fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          pkt_out_d  = w_inject_word;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_count_q != c_cnt_max) begin
          tx_count_d = tx_count_q + 16'd1;
        end
        pkt_out_d = '0;
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = c_gap_load;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - c_gap_w'(1);
        end
      end
      default: begin
        pkt_out_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Receive monitor and bad-destination flag for the following cycle
  always_comb begin
    rx_pulse_d     = rx_data;
    rx_count_d     = rx_count_q;
    err_bad_dest_d = w_accept && w_dest_bad;
    if (rx_data && (rx_count_q != c_cnt_max)) begin
      rx_count_d = rx_count_q + 16'd1;
    end
  end

  // State registers; reset clears pkt_out immediately so no partial packet escapes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pkt_out_q      <= '0;
      gap_cnt_q      <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      rx_pulse_q     <= 1'b0;
      err_bad_dest_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkt_out_q      <= pkt_out_d;
      gap_cnt_q      <= gap_cnt_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      rx_pulse_q     <= rx_pulse_d;
      err_bad_dest_q <= err_bad_dest_d;
    end
  end

  assign pkt_out      = pkt_out_q;
  assign busy         = !w_fifo_empty || (state_q != ST_IDLE);
  assign err_bad_dest = err_bad_dest_q;
  assign rx_pulse     = rx_pulse_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_circ_node_injector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_circ_node_injector
// Description : Self-checking bench for circ_node_injector (GAP=2 and GAP=0
//               instances) using an expected-packet queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circ_node_injector;

  localparam int K  = 8;
  localparam int N2 = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [K-1:0]  router_name;
  logic          req_valid,  req_valid0;
  logic [K-1:0]  req_dest,   req_dest0;
  logic          rx_data,    rx_data0;
  logic          req_ready,  req_ready0;
  logic [N2-1:0] pkt_out,    pkt_out0;
  logic          busy,       busy0;
  logic          err_bad_dest, err_bad_dest0;
  logic          rx_pulse,   rx_pulse0;
  logic [15:0]   tx_count,   tx_count0;
  logic [15:0]   rx_count,   rx_count0;

  int            checks = 0;
  int            errors = 0;
  int            exp_tx = 0;
  logic [N2-1:0] exp_q[$];

  always #5 clk = ~clk;

  circ_node_injector #(
    .NODE_COUNT(225), .K(K), .N2(N2), .FIFO_DEPTH(4), .GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .router_name(router_name),
    .req_valid(req_valid), .req_dest(req_dest), .req_ready(req_ready),
    .pkt_out(pkt_out), .busy(busy), .err_bad_dest(err_bad_dest),
    .rx_data(rx_data), .rx_pulse(rx_pulse),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  circ_node_injector #(
    .NODE_COUNT(225), .K(K), .N2(N2), .FIFO_DEPTH(4), .GAP(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .router_name(router_name),
    .req_valid(req_valid0), .req_dest(req_dest0), .req_ready(req_ready0),
    .pkt_out(pkt_out0), .busy(busy0), .err_bad_dest(err_bad_dest0),
    .rx_data(rx_data0), .rx_pulse(rx_pulse0),
    .tx_count(tx_count0), .rx_count(rx_count0)
  );

  function automatic logic [N2-1:0] inj_word(input int d);
    logic [N2-1:0] w;
    w         = '0;
    w[N2-1]   = 1'b1;
    w[K-1:0]  = d[K-1:0];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pkt_out !== '0) begin errors++; $display("FAIL reset_pkt_out: got %h want 0", pkt_out); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err_bad_dest !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_bad_dest); end
    checks++; if (rx_pulse !== 1'b0) begin errors++; $display("FAIL reset_rx_pulse: got %b want 0", rx_pulse); end
    checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL reset_tx_count: got %h want 0", tx_count); end
    checks++; if (rx_count !== 16'd0) begin errors++; $display("FAIL reset_rx_count: got %h want 0", rx_count); end
    checks++; if (pkt_out0 !== '0) begin errors++; $display("FAIL reset_pkt_out0: got %h want 0", pkt_out0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [N2-1:0] e;
    exp_q.delete();
    req_valid = 1'b1;
    req_dest  = 8'd5;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req_ready); end
    exp_q.push_back(inj_word(5));
    tick();                                   // acceptance edge
    req_valid = 1'b0;
    checks++; if (pkt_out !== '0) begin errors++; $display("FAIL single_early: got %h want 0", pkt_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();                                   // packet visible one cycle after acceptance
    checks++;
    if (pkt_out === '0) begin
      errors++; $display("FAIL single_inject: got %h want %h", pkt_out, 17'h10005);
    end else begin
      e = exp_q.pop_front();
      if (pkt_out !== e) begin errors++; $display("FAIL single_word: got %h want %h", pkt_out, e); end
    end
    tick();
    exp_tx++;
    checks++; if (pkt_out !== '0) begin errors++; $display("FAIL single_width: got %h want 0", pkt_out); end
    checks++; if (tx_count !== 16'(exp_tx)) begin errors++; $display("FAIL single_tx: got %0d want %0d", tx_count, exp_tx); end
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [N2-1:0] e;
    int last, n_inj;
    exp_q.delete();
    last  = -1;
    n_inj = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (pkt_out !== '0) begin
        n_inj++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got %h want none", pkt_out);
        end else begin
          e = exp_q.pop_front();
          if (pkt_out !== e) begin errors++; $display("FAIL b2b_word: got %h want %h", pkt_out, e); end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", cyc - last); end
        end
        last = cyc;
      end
      if (cyc < 5) begin
        req_valid = 1'b1;
        req_dest  = K'(cyc + 1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_hi: got %b want 1 (req %0d)", req_ready, cyc + 1); end
        exp_q.push_back(inj_word(cyc + 1));
      end else if (cyc == 5) begin
        req_valid = 1'b1;                     // offered while full: must be ignored
        req_dest  = 8'd9;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", req_ready); end
      end else if (cyc == 6) begin
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b want 1", req_ready); end
      end
      tick();
    end
    exp_tx += 5;
    checks++; if (n_inj != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", n_inj); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
    checks++; if (tx_count !== 16'(exp_tx)) begin errors++; $display("FAIL b2b_tx: got %0d want %0d", tx_count, exp_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_bad_dest();
    logic [N2-1:0] e;
    int n_inj;
    exp_q.delete();
    req_valid = 1'b1;
    req_dest  = 8'd225;
    tick();
    req_valid = 1'b0;
    checks++; if (err_bad_dest !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b want 1", err_bad_dest); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_not_queued: got %b want 0", busy); end
    tick();
    checks++; if (err_bad_dest !== 1'b0) begin errors++; $display("FAIL bad_err_once: got %b want 0", err_bad_dest); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pkt_out !== '0) begin errors++; $display("FAIL bad_no_inject: got %h want 0", pkt_out); end
      tick();
    end
    checks++; if (tx_count !== 16'(exp_tx)) begin errors++; $display("FAIL bad_tx: got %0d want %0d", tx_count, exp_tx); end
    req_valid = 1'b1;
    req_dest  = 8'd224;
    exp_q.push_back(inj_word(224));
    tick();
    req_valid = 1'b0;
    checks++; if (err_bad_dest !== 1'b0) begin errors++; $display("FAIL bad_edge_err: got %b want 0", err_bad_dest); end
    n_inj = 0;
    for (int i = 0; i < 8; i++) begin
      if (pkt_out !== '0) begin
        n_inj++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bad_extra: got %h want none", pkt_out);
        end else begin
          e = exp_q.pop_front();
          if (pkt_out !== e) begin errors++; $display("FAIL bad_224_word: got %h want %h", pkt_out, e); end
        end
      end
      tick();
    end
    exp_tx++;
    checks++; if (n_inj != 1) begin errors++; $display("FAIL bad_224_count: got %0d want 1", n_inj); end
    checks++; if (tx_count !== 16'(exp_tx)) begin errors++; $display("FAIL bad_224_tx: got %0d want %0d", tx_count, exp_tx); end
  endtask

  task automatic test_rx();
    for (int i = 0; i < 5; i++) begin
      rx_data = (i < 3);
      tick();
      checks++; if (rx_pulse !== logic'(i < 3)) begin errors++; $display("FAIL rx_pulse_lag: got %b want %b (cycle %0d)", rx_pulse, (i < 3), i); end
      checks++; if (rx_count !== 16'((i < 3) ? i + 1 : 3)) begin errors++; $display("FAIL rx_count: got %0d want %0d", rx_count, (i < 3) ? i + 1 : 3); end
    end
    rx_data = 1'b1;
    repeat (65531) @(posedge clk);
    #1;
    rx_data = 1'b0;
    checks++; if (rx_count !== 16'hFFFE) begin errors++; $display("FAIL rx_preset: got %h want fffe", rx_count); end
    rx_data = 1'b1;
    tick();
    checks++; if (rx_count !== 16'hFFFF) begin errors++; $display("FAIL rx_reach_max: got %h want ffff", rx_count); end
    tick();
    rx_data = 1'b0;
    checks++; if (rx_count !== 16'hFFFF) begin errors++; $display("FAIL rx_saturate: got %h want ffff", rx_count); end
    tick();
    checks++; if (rx_pulse !== 1'b0) begin errors++; $display("FAIL rx_pulse_fall: got %b want 0", rx_pulse); end
  endtask

  task automatic test_reset_mid();
    logic [N2-1:0] e;
    int n_bad;
    exp_q.delete();
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (pkt_out !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rstmid_extra: got %h want none", pkt_out);
        end else begin
          e = exp_q.pop_front();
          if (pkt_out !== e) begin errors++; $display("FAIL rstmid_first: got %h want %h", pkt_out, e); end
        end
      end
      if (cyc < 4) begin
        req_valid = 1'b1;
        req_dest  = K'(10 + cyc);
        exp_q.push_back(inj_word(10 + cyc));
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    // Second packet is in SEND now with two more requests queued
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL rstmid_send: got %h want packet", pkt_out);
    end else begin
      e = exp_q.pop_front();
      if (pkt_out !== e) begin errors++; $display("FAIL rstmid_send: got %h want %h", pkt_out, e); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pkt_out !== '0) begin errors++; $display("FAIL rstmid_async_pkt: got %h want 0", pkt_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_async_busy: got %b want 0", busy); end
    exp_q.delete();
    exp_tx = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pkt_out !== '0) n_bad++;
    end
    checks++; if (n_bad != 0) begin errors++; $display("FAIL rstmid_no_inject: got %0d nonzero cycles want 0", n_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL rstmid_tx: got %0d want 0", tx_count); end
    checks++; if (rx_count !== 16'd0) begin errors++; $display("FAIL rstmid_rx: got %0d want 0", rx_count); end
  endtask

  task automatic test_gap0();
    logic [N2-1:0] e;
    int last, n_inj;
    exp_q.delete();
    last  = -1;
    n_inj = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (pkt_out0 !== '0) begin
        n_inj++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL gap0_extra: got %h want none", pkt_out0);
        end else begin
          e = exp_q.pop_front();
          if (pkt_out0 !== e) begin errors++; $display("FAIL gap0_word: got %h want %h", pkt_out0, e); end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 2) begin errors++; $display("FAIL gap0_spacing: got %0d want 2", cyc - last); end
        end
        last = cyc;
      end
      if (cyc == 6) begin
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL gap0_busy_last: got %b want 1", busy0); end
      end
      if (cyc == 7) begin
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL gap0_busy_done: got %b want 0", busy0); end
      end
      if (cyc < 3) begin
        req_valid0 = 1'b1;
        req_dest0  = K'(20 + cyc);
        checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL gap0_ready: got %b want 1", req_ready0); end
        exp_q.push_back(inj_word(20 + cyc));
      end else begin
        req_valid0 = 1'b0;
      end
      tick();
    end
    checks++; if (n_inj != 3) begin errors++; $display("FAIL gap0_count: got %0d want 3", n_inj); end
    checks++; if (tx_count0 !== 16'd3) begin errors++; $display("FAIL gap0_tx: got %0d want 3", tx_count0); end
  endtask

  initial begin
    rst_n       = 1'b0;
    router_name = 8'd0;
    req_valid   = 1'b0;
    req_dest    = '0;
    rx_data     = 1'b0;
    req_valid0  = 1'b0;
    req_dest0   = '0;
    rx_data0    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_dest();
    test_rx();
    test_reset_mid();
    test_gap0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
